// File: rtl/uart_rx_stb.sv
// 8N1 UART receiver with a one-entry strobe/ack output buffer; byte appears one cycle after the mid-stop-bit sample.
// Holds the byte until o_ack; a byte completing while the buffer is full and not being accepted is dropped with an overrun pulse.
module uart_rx_stb #(
    parameter int CLK_DIV = 434,
    parameter int WIDTH   = 8
) (
    input  logic             CLK,
    input  logic             RST_N,
    input  logic             rx,
    output logic [WIDTH-1:0] o_data,
    output logic             o_stb,
    input  logic             o_ack,
    output logic             frame_err,
    output logic             overrun
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP,
        S_WAIT_HIGH
    } state_t;

    localparam int              BW       = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [15:0]     HALF_M1  = 16'(CLK_DIV / 2 - 1);
    localparam logic [15:0]     FULL_M1  = 16'(CLK_DIV - 1);
    localparam logic [BW-1:0]   LAST_BIT = BW'(WIDTH - 1);

    logic             r_sync1;
    logic             r_rx_s;
    state_t           r_state;
    state_t           w_next;
    logic [15:0]      r_cnt;
    logic [BW-1:0]    r_bitn;
    logic [WIDTH-1:0] r_shreg;
    logic [WIDTH-1:0] r_data;
    logic             r_stb;
    logic             r_ferr;
    logic             r_ovr;

    logic             w_cnt_zero;
    logic             w_done;
    logic             w_ferr_ev;
    logic             w_accept;
    logic             w_load;

    // Both stages reset high so an idle line never looks like a start bit.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
        end else begin
            r_sync1 <= rx;
            r_rx_s  <= r_sync1;
        end
    end

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    assign w_cnt_zero = (r_cnt == 16'd0);

    always_comb begin
        w_next    = r_state;
        w_done    = 1'b0;
        w_ferr_ev = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (!r_rx_s) w_next = S_START;
            end
            S_START: begin
                if (w_cnt_zero) w_next = r_rx_s ? S_IDLE : S_DATA;
            end
            S_DATA: begin
                if (w_cnt_zero && (r_bitn == LAST_BIT)) w_next = S_STOP;
            end
            S_STOP: begin
                if (w_cnt_zero) begin
                    if (r_rx_s) begin
                        w_done = 1'b1;
                        w_next = S_IDLE;
                    end else begin
                        w_ferr_ev = 1'b1;
                        w_next    = S_WAIT_HIGH;
                    end
                end
            end
            S_WAIT_HIGH: begin
                if (r_rx_s) w_next = S_IDLE;
            end
            default: w_next = S_IDLE;
        endcase
    end

    assign w_accept = r_stb & o_ack;
    assign w_load   = w_done & (~r_stb | w_accept);

    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_cnt   <= 16'd0;
            r_bitn  <= '0;
            r_shreg <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (!r_rx_s) r_cnt <= HALF_M1;
                end
                S_START: begin
                    if (w_cnt_zero) begin
                        r_cnt  <= FULL_M1;
                        r_bitn <= '0;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_cnt_zero) begin
                        r_cnt   <= FULL_M1;
                        r_shreg <= {r_rx_s, r_shreg[WIDTH-1:1]};
                        if (r_bitn != LAST_BIT) r_bitn <= r_bitn + 1'b1;
                    end else begin
                        r_cnt <= r_cnt - 16'd1;
                    end
                end
                S_STOP: begin
                    if (!w_cnt_zero) r_cnt <= r_cnt - 16'd1;
                end
                default: ;
            endcase
        end
    end

    // A completion in the same cycle as an accept refills the buffer, so o_stb stays high.
    always_ff @(posedge CLK or negedge RST_N) begin
        if (!RST_N) begin
            r_data <= '0;
            r_stb  <= 1'b0;
            r_ferr <= 1'b0;
            r_ovr  <= 1'b0;
        end else begin
            if (w_load) begin
                r_data <= r_shreg;
                r_stb  <= 1'b1;
            end else if (w_accept) begin
                r_stb <= 1'b0;
            end
            r_ferr <= w_ferr_ev;
            r_ovr  <= w_done & r_stb & ~o_ack;
        end
    end

    assign o_data    = r_data;
    assign o_stb     = r_stb;
    assign frame_err = r_ferr;
    assign overrun   = r_ovr;

endmodule

// File: tb/tb_uart_rx_stb.sv
// Directed bench for uart_rx_stb at CLK_DIV=16: byte timing, back-pressure, overrun, accept/complete overlap, framing, glitch, reset.
module tb_uart_rx_stb;

    localparam int D     = 16;
    localparam int W     = 8;
    localparam int FRAME = (W + 2) * D;
    // rx drive -> 2 sync flops -> detect edge E, then half bit plus start/data bits to the stop sample.
    localparam int LAT   = 3 + D / 2 + (W + 1) * D;

    logic         CLK = 1'b0;
    logic         RST_N;
    logic         rx;
    logic [W-1:0] o_data;
    logic         o_stb;
    logic         o_ack;
    logic         frame_err;
    logic         overrun;

    uart_rx_stb #(.CLK_DIV(D), .WIDTH(W)) dut (
        .CLK       (CLK),
        .RST_N     (RST_N),
        .rx        (rx),
        .o_data    (o_data),
        .o_stb     (o_stb),
        .o_ack     (o_ack),
        .frame_err (frame_err),
        .overrun   (overrun)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc <= cyc + 1;

    int n_assert = 0;
    int n_fail   = 0;

    logic [W-1:0] exp_q[$];
    logic [W-1:0] got_q[$];

    int           stb_cycles = 0;
    int           rise_cyc   = -1;
    int           ferr_cnt   = 0;
    int           ferr_cyc   = -1;
    int           ovr_cnt    = 0;
    int           ovr_cyc    = -1;
    int           hold_bad   = 0;
    logic         prev_stb   = 1'b0;
    logic         prev_ack   = 1'b0;
    logic [W-1:0] prev_data  = '0;

    always @(negedge CLK) begin
        if (!RST_N) begin
            prev_stb = 1'b0;
            prev_ack = 1'b0;
        end else begin
            if (prev_stb && !prev_ack && (o_stb !== 1'b1 || o_data !== prev_data)) hold_bad++;
            if (o_stb && !prev_stb) rise_cyc = cyc;
            if (o_stb) stb_cycles++;
            if (frame_err) begin
                ferr_cnt++;
                ferr_cyc = cyc;
            end
            if (overrun) begin
                ovr_cnt++;
                ovr_cyc = cyc;
            end
            if (o_stb && o_ack) got_q.push_back(o_data);
            prev_stb  = o_stb;
            prev_ack  = o_ack;
            prev_data = o_data;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge CLK);
            #1;
        end
    endtask

    // Drives one frame for ncyc cycles; o_ack is pulsed for one cycle at offset ack_at when ack_at >= 0.
    task automatic tx_byte(input logic [W-1:0] b, input logic stop_bit, input int ack_at, input int ncyc);
        logic [W-1:0] bb;
        int           slot;
        bb = b;
        for (int n = 0; n < ncyc; n++) begin
            slot = n / D;
            if (slot == 0)      rx = 1'b0;
            else if (slot <= W) rx = bb[3'(slot - 1)];
            else                rx = stop_bit;
            if (ack_at >= 0) o_ack = (n == ack_at);
            tick(1);
        end
        rx = 1'b1;
    endtask

    task automatic drain(input string tag);
        while (exp_q.size() > 0) begin
            if (got_q.size() == 0) begin
                check({tag, "_missing"}, 32'(exp_q.size()), 32'd0);
                exp_q.delete();
            end else begin
                check(tag, 32'(got_q.pop_front()), 32'(exp_q.pop_front()));
            end
        end
        check({tag, "_extra"}, 32'(got_q.size()), 32'd0);
        got_q.delete();
    endtask

    initial begin
        int t0;
        int b0;
        int f0;
        int v0;
        bit ok;

        RST_N = 1'b0;
        rx    = 1'b1;
        o_ack = 1'b0;
        tick(3);
        check("rst_stb",   32'(o_stb),     32'd0);
        check("rst_data",  32'(o_data),    32'd0);
        check("rst_ferr",  32'(frame_err), 32'd0);
        check("rst_ovr",   32'(overrun),   32'd0);
        RST_N = 1'b1;
        tick(5);

        // Single byte, ack tied high.
        o_ack = 1'b1;
        b0 = stb_cycles; f0 = ferr_cnt; v0 = ovr_cnt;
        exp_q.push_back(8'h52);
        t0 = cyc;
        tx_byte(8'h52, 1'b1, -1, FRAME);
        tick(10);
        check("t1_rise_cyc",   32'(rise_cyc),          32'(t0 + LAT));
        check("t1_stb_cycles", 32'(stb_cycles - b0),   32'd1);
        check("t1_ferr",       32'(ferr_cnt - f0),     32'd0);
        check("t1_ovr",        32'(ovr_cnt - v0),      32'd0);
        drain("t1_byte");

        // Back-pressure.
        o_ack = 1'b0;
        exp_q.push_back(8'h57);
        tx_byte(8'h57, 1'b1, -1, FRAME);
        ok = 1'b1;
        for (int i = 0; i < 500; i++) begin
            tick(1);
            if (o_stb !== 1'b1 || o_data !== 8'h57) ok = 1'b0;
        end
        check("t2_held", 32'(ok), 32'd1);
        o_ack = 1'b1;
        tick(1);
        check("t2_fall", 32'(o_stb), 32'd0);
        drain("t2_byte");

        // Overrun.
        o_ack = 1'b0;
        v0 = ovr_cnt;
        exp_q.push_back(8'h11);
        tx_byte(8'h11, 1'b1, -1, FRAME);
        t0 = cyc;
        tx_byte(8'h22, 1'b1, -1, FRAME);
        tick(5);
        check("t3_data",    32'(o_data),        32'h11);
        check("t3_stb",     32'(o_stb),         32'd1);
        check("t3_ovr_cnt", 32'(ovr_cnt - v0),  32'd1);
        check("t3_ovr_cyc", 32'(ovr_cyc),       32'(t0 + LAT));
        o_ack = 1'b1;
        tick(1);
        check("t3_drop", 32'(o_stb), 32'd0);
        drain("t3_first");
        exp_q.push_back(8'h33);
        tx_byte(8'h33, 1'b1, -1, FRAME);
        tick(5);
        drain("t3_next");

        // Accept in the very cycle the next byte completes.
        o_ack = 1'b0;
        v0 = ovr_cnt;
        exp_q.push_back(8'hAA);
        tx_byte(8'hAA, 1'b1, -1, FRAME);
        tick(5);
        tx_byte(8'h55, 1'b1, LAT - 1, FRAME);
        tick(2);
        drain("t4_old");
        check("t4_stb",  32'(o_stb),        32'd1);
        check("t4_data", 32'(o_data),       32'h55);
        check("t4_ovr",  32'(ovr_cnt - v0), 32'd0);
        exp_q.push_back(8'h55);
        o_ack = 1'b1;
        tick(1);
        o_ack = 1'b0;
        drain("t4_new");

        // Framing error followed by a held break.
        o_ack = 1'b1;
        b0 = stb_cycles; f0 = ferr_cnt;
        t0 = cyc;
        tx_byte(8'hFF, 1'b0, -1, FRAME);
        rx = 1'b0;
        tick(40);
        check("t5_ferr_cnt", 32'(ferr_cnt - f0),   32'd1);
        check("t5_ferr_cyc", 32'(ferr_cyc),        32'(t0 + LAT));
        check("t5_stb",      32'(stb_cycles - b0), 32'd0);
        rx = 1'b1;
        tick(200);
        check("t5_break_ferr", 32'(ferr_cnt - f0),   32'd1);
        check("t5_break_stb",  32'(stb_cycles - b0), 32'd0);

        // Short glitch on an idle line.
        b0 = stb_cycles; f0 = ferr_cnt;
        rx = 1'b0;
        tick(3);
        rx = 1'b1;
        tick(200);
        check("t5_glitch_stb",  32'(stb_cycles - b0), 32'd0);
        check("t5_glitch_ferr", 32'(ferr_cnt - f0),   32'd0);

        // Reset during data bit 4 while a byte is held.
        o_ack = 1'b0;
        tx_byte(8'h3C, 1'b1, -1, FRAME);
        tick(5);
        check("t6_pre_stb", 32'(o_stb), 32'd1);
        tx_byte(8'hC3, 1'b1, -1, 5 * D + 8);
        rx = 1'b0;
        RST_N = 1'b0;
        #1;
        check("t6_rst_stb",  32'(o_stb),     32'd0);
        check("t6_rst_data", 32'(o_data),    32'd0);
        check("t6_rst_ferr", 32'(frame_err), 32'd0);
        check("t6_rst_ovr",  32'(overrun),   32'd0);
        rx = 1'b1;
        tick(3);
        RST_N = 1'b1;
        tick(20);
        o_ack = 1'b1;
        b0 = stb_cycles;
        exp_q.push_back(8'hA5);
        tx_byte(8'hA5, 1'b1, -1, FRAME);
        tick(5);
        drain("t6_byte");
        check("t6_stb_cycles", 32'(stb_cycles - b0), 32'd1);
        check("hold_stable",   32'(hold_bad),        32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx_stb.md
# uart_rx_stb

UART receiver that deserializes an 8N1 serial line into bytes and presents them on a strobe/acknowledge byte port. It sits directly upstream of the UART-to-SDRAM command parser and drives that parser's `i_data`/`i_stb` inputs. It also consumes the parser's `i_ack`. The block holds one received byte until it is acknowledged, and reports framing errors and overruns as single-cycle pulses.

## Interface
- `CLK_DIV`, default 434: CLK cycles per bit (50 MHz / 115200). Legal values are 4 to 65535.
- `WIDTH`, default 8: data bits per frame. It must match the parser's `width`.
- `CLK`, in, 1: system clock. All logic is on the rising edge.
- `RST_N`, in, 1: reset. **One clock; reset is asynchronous and active-low.**
- `rx`, in, 1: serial line. It is asynchronous to `CLK` and idles high.
- `o_data`, out, WIDTH: held byte, LSB = first data bit received.
- `o_stb`, out, 1: `o_data` is valid.
- `o_ack`, in, 1: consumer accepts the byte. Acceptance occurs in the cycle where `o_stb & o_ack` are both high.
- `frame_err`, out, 1: one-cycle pulse when the stop bit is sampled low.
- `overrun`, out, 1: one-cycle pulse when a completed byte is dropped.

## Operation
- **Synchronizer:** `rx` passes through a 2-flop synchronizer to `rx_s`. Both flops reset to 1, so no false start occurs after reset.
- **Bit timer:** 16-bit down-counter `cnt`. A bit counter `bitn` runs 0..WIDTH-1.
- **FSM states:** IDLE, START, DATA, STOP, WAIT_HIGH.
  - **IDLE:** if `rx_s==0`, go to START and load `cnt <= CLK_DIV/2 - 1` (integer division).
  - **START:** decrement `cnt`. At `cnt==0`, sample `rx_s`.
    - If the sample is 0: go to DATA, load `cnt <= CLK_DIV-1`, and set `bitn <= 0`.
    - If the sample is 1: go to IDLE (glitch rejected, no pulse).
  - **DATA:** at `cnt==0`, shift `rx_s` into `shreg` MSB-first so that the first bit ends in the LSB, and reload `cnt`.
    - At `bitn==WIDTH-1`, go to STOP.
    - Otherwise, increment `bitn`.
  - **STOP:** at `cnt==0`, sample `rx_s`.
    - If the sample is 1: the byte completes and the FSM goes to IDLE.
    - If the sample is 0: pulse `frame_err`, discard the byte, and go to WAIT_HIGH.
  - **WAIT_HIGH:** stay until `rx_s==1`, then go to IDLE. This prevents a break condition from being decoded as repeated frames.
- **Output buffer (one entry), on the byte-complete cycle C:**
  - If `o_stb==0`, or `o_stb & o_ack` in cycle C: `o_data <= shreg` and `o_stb <= 1`.
  - Otherwise: keep the old byte, drop the new one, and pulse `overrun` in cycle C+1.
- **Consumption:** if `o_stb & o_ack` with no completion in the same cycle, `o_stb <= 0` on the next edge.
- `o_data` is stable whenever `o_stb==1`. `o_ack` while `o_stb==0` is ignored.
- **Reset (any time, including mid-frame):**
  - State goes to IDLE; `cnt`, `bitn`, `shreg` and `o_data` go to 0.
  - `o_stb`, `frame_err` and `overrun` go to 0; the synchronizer flops go to 1.
  - After release, a partially received frame is ignored until a fresh falling edge arrives.

## Timing
- Let E be the first CLK edge at which `rx_s==0` in IDLE. START is entered at E+1.
- The start sample is at E+CLK_DIV/2.
- Data bit k is sampled at E+CLK_DIV/2+(k+1)·CLK_DIV.
- The stop sample (cycle C) is at E+CLK_DIV/2+(WIDTH+1)·CLK_DIV.
- `o_stb` is high from C+1. `frame_err` and `overrun` are high for exactly cycle C+1.
- The `rx` pin-to-`rx_s` delay is 2 cycles.
- The FSM is back in IDLE at C+1, so a start bit immediately following the stop bit's midpoint is caught. This tolerates roughly ±4% baud mismatch.
- All outputs are registered; there is no combinational path from `o_ack` or `rx` to any output.

## Test plan
- **Single byte:** CLK_DIV=16, send 0x52 ('R') with `o_ack` tied high.
  - Expect `o_stb` high for exactly 1 cycle at E+8+144+1, with `o_data`=0x52.
  - Expect no `frame_err` or `overrun`.
- **Back-pressure:** send 0x57 with `o_ack` held low for 500 cycles.
  - Expect `o_stb`=1 and `o_data`=0x57 held throughout.
  - Expect `o_stb` to fall 1 cycle after `o_ack` rises.
- **Overrun:** keep `o_ack` low and send 0x11 then 0x22.
  - Expect `o_data`=0x11 to be kept and `overrun` to pulse once at the second byte's C+1.
  - Then assert `o_ack`: expect `o_stb` to drop, and a subsequent byte 0x33 is received correctly.
- **Simultaneous accept/complete:** with 0xAA held, assert `o_ack` exactly in the cycle 0x55 completes.
  - Expect `o_stb` to remain 1, `o_data`=0x55 from C+1, and no `overrun`.
- **Framing and glitch:**
  - Send 0xFF with the stop bit low, then hold `rx` low 40 cycles: expect `frame_err` to pulse once, `o_stb` to stay 0, and no further frames until `rx` returns high.
  - A 3-cycle low glitch on idle `rx` (CLK_DIV=16) produces no activity.
- **Reset mid-frame:** assert `RST_N` low during data bit 4, then release.
  - Expect all outputs 0 immediately (asynchronously).
  - The next clean frame 0xA5 is received correctly.
